// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU-op classes,
// control FSM states and datapath mux select codes.
package mips_ctl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // ALU-op classes, also decoded by ALU control
  localparam logic [2:0] ALU_OP_R    = 3'b111;
  localparam logic [2:0] ALU_OP_ADD  = 3'b100;
  localparam logic [2:0] ALU_OP_ORI  = 3'b101;
  localparam logic [2:0] ALU_OP_ANDI = 3'b001;
  localparam logic [2:0] ALU_OP_LUI  = 3'b110;
  localparam logic [2:0] ALU_OP_MEM  = 3'b011;
  localparam logic [2:0] ALU_OP_SUB  = 3'b010;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

  localparam logic [1:0] SRC_B_B        = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] JMP_CTL_JR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL_ST    = 4'd12
  } state_e;

  typedef struct packed {
    logic mem;
    logic r;
    logic imm;
    logic branch;
    logic jump;
    logic jal;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/ALU-control bundle. master = control unit, slave = datapath.
interface multicycle_control_unit_if;
  logic [5:0] opcode_i;
  logic [1:0] jmp_ctl_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       branch_ne_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic [1:0] reg_dst_o;
  logic [1:0] mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       zero_ext_o;
  logic [1:0] pc_source_o;
  logic [2:0] alu_op_o;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  opcode_i, jmp_ctl_i,
    output pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, zero_ext_o, pc_source_o, alu_op_o,
           illegal_o, state_o
  );

  modport slave (
    output opcode_i, jmp_ctl_i,
    input  pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
           mem_write_o, ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, zero_ext_o, pc_source_o, alu_op_o,
           illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_control_unit_opcode_class_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus the ALU op
// and immediate extension mode used by I-type arithmetic.
module opcode_class_decoder
  import mips_ctl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu_op,
  output logic       imm_zero_ext
);

  always_comb begin
    op_class     = '0;
    imm_alu_op   = ALU_OP_ADD;
    imm_zero_ext = 1'b0;
    case (opcode)
      OP_LW, OP_SW:    op_class.mem    = 1'b1;
      OP_R:            op_class.r      = 1'b1;
      OP_BEQ, OP_BNE:  op_class.branch = 1'b1;
      OP_J:            op_class.jump   = 1'b1;
      OP_JAL:          op_class.jal    = 1'b1;
      OP_ADDI:         op_class.imm    = 1'b1;
      OP_ANDI: begin
        op_class.imm = 1'b1;
        imm_alu_op   = ALU_OP_ANDI;
        imm_zero_ext = 1'b1;
      end
      OP_ORI: begin
        op_class.imm = 1'b1;
        imm_alu_op   = ALU_OP_ORI;
        imm_zero_ext = 1'b1;
      end
      OP_LUI: begin
        op_class.imm = 1'b1;
        imm_alu_op   = ALU_OP_LUI;
      end
      default:         op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS datapath. Moore outputs decoded from the
// state register, with Mealy terms for JR completion in R_EXEC and illegal_o in DECODE.
//
// state       | meaning
// FETCH       | read instruction, IR <- mem, PC <- PC+4
// DECODE      | ALUOut <- branch target, dispatch on opcode
// MEM_ADDR    | ALUOut <- A + sign-extended offset
// MEM_READ    | MDR <- mem[ALUOut]
// MEM_WB      | rt <- MDR
// MEM_WRITE   | mem[ALUOut] <- B
// R_EXEC      | ALU on A,B; JR loads PC from A and finishes here
// R_WB        | rd <- ALUOut
// I_EXEC      | ALU on A, extended immediate
// I_WB        | rt <- ALUOut
// BRANCH      | compare A,B; conditional PC <- ALUOut
// JUMP        | PC <- jump target
// JAL_ST      | PC <- jump target, $31 <- PC
module multicycle_control_unit
  import mips_ctl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_e    state;
  state_e    state_next;
  op_class_t op_class;
  logic [2:0] imm_alu_op;
  logic       imm_zero_ext;

  opcode_class_decoder u_decoder (
    .opcode       (bus.opcode_i),
    .op_class     (op_class),
    .imm_alu_op   (imm_alu_op),
    .imm_zero_ext (imm_zero_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Reset gates every output to zero so an aborted instruction cannot write.
  always_comb begin
    state_next          = S_FETCH;
    bus.pc_write_o      = 1'b0;
    bus.pc_write_cond_o = 1'b0;
    bus.branch_ne_o     = 1'b0;
    bus.i_or_d_o        = 1'b0;
    bus.mem_read_o      = 1'b0;
    bus.mem_write_o     = 1'b0;
    bus.ir_write_o      = 1'b0;
    bus.reg_write_o     = 1'b0;
    bus.reg_dst_o       = REG_DST_RT;
    bus.mem_to_reg_o    = MEM_TO_REG_ALUOUT;
    bus.alu_src_a_o     = 1'b0;
    bus.alu_src_b_o     = SRC_B_B;
    bus.zero_ext_o      = 1'b0;
    bus.pc_source_o     = PC_SRC_ALU;
    bus.alu_op_o        = 3'b000;
    bus.illegal_o       = 1'b0;
    bus.state_o         = 4'd0;
    if (!reset) begin
      bus.state_o = state;
      case (state)
        S_FETCH: begin
          bus.mem_read_o  = 1'b1;
          bus.ir_write_o  = 1'b1;
          bus.pc_write_o  = 1'b1;
          bus.alu_src_b_o = SRC_B_FOUR;
          bus.alu_op_o    = ALU_OP_ADD;
          bus.pc_source_o = PC_SRC_ALU;
          state_next      = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_b_o = SRC_B_IMM_SHL2;
          bus.alu_op_o    = ALU_OP_ADD;
          if (op_class.mem)         state_next = S_MEM_ADDR;
          else if (op_class.r)      state_next = S_R_EXEC;
          else if (op_class.imm)    state_next = S_I_EXEC;
          else if (op_class.branch) state_next = S_BRANCH;
          else if (op_class.jump)   state_next = S_JUMP;
          else if (op_class.jal)    state_next = S_JAL_ST;
          else                      bus.illegal_o = op_class.illegal;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.alu_op_o    = ALU_OP_MEM;
          state_next      = (bus.opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          bus.mem_read_o = 1'b1;
          bus.i_or_d_o   = 1'b1;
          state_next     = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.reg_dst_o    = REG_DST_RT;
          bus.mem_to_reg_o = MEM_TO_REG_MDR;
        end
        S_MEM_WRITE: begin
          bus.mem_write_o = 1'b1;
          bus.i_or_d_o    = 1'b1;
        end
        S_R_EXEC: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = SRC_B_B;
          bus.alu_op_o    = ALU_OP_R;
          if (bus.jmp_ctl_i == JMP_CTL_JR) begin
            bus.pc_write_o  = 1'b1;
            bus.pc_source_o = PC_SRC_REG;
          end else begin
            state_next = S_R_WB;
          end
        end
        S_R_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.reg_dst_o    = REG_DST_RD;
          bus.mem_to_reg_o = MEM_TO_REG_ALUOUT;
        end
        S_I_EXEC: begin
          bus.alu_src_a_o = 1'b1;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.alu_op_o    = imm_alu_op;
          bus.zero_ext_o  = imm_zero_ext;
          state_next      = S_I_WB;
        end
        S_I_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.reg_dst_o    = REG_DST_RT;
          bus.mem_to_reg_o = MEM_TO_REG_ALUOUT;
          bus.alu_op_o     = imm_alu_op;
          bus.zero_ext_o   = imm_zero_ext;
        end
        S_BRANCH: begin
          bus.alu_src_a_o     = 1'b1;
          bus.alu_src_b_o     = SRC_B_B;
          bus.alu_op_o        = ALU_OP_SUB;
          bus.pc_write_cond_o = 1'b1;
          bus.pc_source_o     = PC_SRC_ALUOUT;
          bus.branch_ne_o     = (bus.opcode_i == OP_BNE);
        end
        S_JUMP: begin
          bus.pc_write_o  = 1'b1;
          bus.pc_source_o = PC_SRC_JUMP;
        end
        S_JAL_ST: begin
          bus.pc_write_o   = 1'b1;
          bus.pc_source_o  = PC_SRC_JUMP;
          bus.reg_write_o  = 1'b1;
          bus.reg_dst_o    = REG_DST_RA;
          bus.mem_to_reg_o = MEM_TO_REG_PC;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a random
// instruction stream, each cycle compared against a per-instruction cycle table model.
module tb_multicycle_control_unit;
  import mips_ctl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
    logic [3:0] state;
  } ctl_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic ctl_t observe();
    ctl_t o;
    o.pc_write      = bus.pc_write_o;
    o.pc_write_cond = bus.pc_write_cond_o;
    o.branch_ne     = bus.branch_ne_o;
    o.i_or_d        = bus.i_or_d_o;
    o.mem_read      = bus.mem_read_o;
    o.mem_write     = bus.mem_write_o;
    o.ir_write      = bus.ir_write_o;
    o.reg_write     = bus.reg_write_o;
    o.reg_dst       = bus.reg_dst_o;
    o.mem_to_reg    = bus.mem_to_reg_o;
    o.alu_src_a     = bus.alu_src_a_o;
    o.alu_src_b     = bus.alu_src_b_o;
    o.zero_ext      = bus.zero_ext_o;
    o.pc_source     = bus.pc_source_o;
    o.alu_op        = bus.alu_op_o;
    o.illegal       = bus.illegal_o;
    o.state         = bus.state_o;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                      OP_ORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  function automatic int cpi(input logic [5:0] op, input logic [1:0] jmp);
    case (op)
      OP_LW:                               return 5;
      OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return 4;
      OP_R:                                return (jmp == 2'b10) ? 3 : 4;
      OP_BEQ, OP_BNE, OP_J, OP_JAL:        return 3;
      default:                             return 2;
    endcase
  endfunction

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return 3'b001;
      OP_ORI:  return 3'b101;
      OP_LUI:  return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  // Expected outputs for cycle 'step' (0 = fetch) of instruction 'op'.
  function automatic ctl_t model(input logic [5:0] op, input logic [1:0] jmp, input int step);
    ctl_t e = '0;
    if (step == 0) begin
      e.mem_read = 1; e.ir_write = 1; e.pc_write = 1;
      e.alu_src_b = 2'b01; e.alu_op = 3'b100; e.state = S_FETCH;
    end else if (step == 1) begin
      e.alu_src_b = 2'b11; e.alu_op = 3'b100; e.state = S_DECODE;
      e.illegal = !is_legal(op);
    end else begin
      case (op)
        OP_LW, OP_SW: begin
          if (step == 2) begin
            e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b011; e.state = S_MEM_ADDR;
          end else if (step == 3 && op == OP_LW) begin
            e.mem_read = 1; e.i_or_d = 1; e.state = S_MEM_READ;
          end else if (step == 3) begin
            e.mem_write = 1; e.i_or_d = 1; e.state = S_MEM_WRITE;
          end else begin
            e.reg_write = 1; e.mem_to_reg = 2'b01; e.state = S_MEM_WB;
          end
        end
        OP_R: begin
          if (step == 2) begin
            e.alu_src_a = 1; e.alu_op = 3'b111; e.state = S_R_EXEC;
            if (jmp == 2'b10) begin e.pc_write = 1; e.pc_source = 2'b11; end
          end else begin
            e.reg_write = 1; e.reg_dst = 2'b01; e.state = S_R_WB;
          end
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
          e.alu_op = imm_op(op);
          e.zero_ext = (op == OP_ANDI || op == OP_ORI);
          if (step == 2) begin
            e.alu_src_a = 1; e.alu_src_b = 2'b10; e.state = S_I_EXEC;
          end else begin
            e.reg_write = 1; e.state = S_I_WB;
          end
        end
        OP_BEQ, OP_BNE: begin
          e.alu_src_a = 1; e.alu_op = 3'b010; e.pc_write_cond = 1;
          e.pc_source = 2'b01; e.branch_ne = (op == OP_BNE); e.state = S_BRANCH;
        end
        OP_J: begin
          e.pc_write = 1; e.pc_source = 2'b10; e.state = S_JUMP;
        end
        OP_JAL: begin
          e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1;
          e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.state = S_JAL_ST;
        end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  // Entered and left at posedge+1; opcode is junk during fetch since the IR loads at its end.
  task automatic run_steps(input logic [5:0] op, input logic [1:0] jmp, input int nsteps,
                           input string name);
    ctl_t got, exp;
    for (int s = 0; s < nsteps; s++) begin
      bus.opcode_i  = (s == 0) ? 6'($urandom) : op;
      bus.jmp_ctl_i = jmp;
      #1;
      got = observe();
      exp = model(op, jmp, s);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s op=%b jmp=%b step %0d: got %h expected %h", name, op, jmp, s, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [1:0] jmp, input string name);
    run_steps(op, jmp, cpi(op, jmp), name);
  endtask

  task automatic check_all_zero(input string name);
    ctl_t got;
    #1;
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: got %h expected all zero", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode_i = OP_LW;
    bus.jmp_ctl_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_initial");
    reset = 1'b0;
    run_steps(OP_LW, 2'b00, 3, "lw_before_abort");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_all_zero("reset_mid_lw");
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 2'b00, "lw");
    run_instr(OP_SW, 2'b00, "sw");
  endtask

  task automatic test_r_and_jr();
    run_instr(OP_R, 2'b00, "r_add");
    run_instr(OP_R, 2'b10, "jr");
  endtask

  task automatic test_branch();
    run_instr(OP_BNE, 2'b00, "bne");
    run_instr(OP_BEQ, 2'b00, "beq");
  endtask

  task automatic test_ori_jal();
    run_instr(OP_ORI, 2'b00, "ori");
    run_instr(OP_JAL, 2'b00, "jal");
    run_instr(OP_J, 2'b01, "j");
    run_instr(OP_ANDI, 2'b00, "andi");
    run_instr(OP_LUI, 2'b00, "lui");
    run_instr(OP_ADDI, 2'b00, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 2'b00, "illegal");
    run_instr(OP_R, 2'b00, "after_illegal");
  endtask

  task automatic test_random();
    logic [5:0] legal [11] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                               OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    logic [5:0] op;
    logic [1:0] jmp;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else                           op = legal[$urandom_range(0, 10)];
      jmp = 2'($urandom);
      run_instr(op, jmp, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_r_and_jr();
    test_branch();
    test_ori_jal();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main control FSM for the multicycle MIPS datapath, sitting directly upstream of ALU control.
- Decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and write-back cycles.
- Drives the 3-bit ALU operation class consumed by ALU control, plus all datapath enables and mux selects.
- Samples the jump-control code returned by ALU control so that JR completes without a write-back.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode_i  input  6  instruction[31:26] from instruction register
- jmp_ctl_i  input  2  from ALU control; 2'b10 = JR
- pc_write_o  output  1  unconditional PC load
- pc_write_cond_o  output  1  conditional PC load; datapath loads when zero XOR branch_ne_o
- branch_ne_o  output  1  1 = BNE sense
- i_or_d_o  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read_o / mem_write_o  output  1 each  memory strobes
- ir_write_o  output  1  instruction register load
- reg_write_o  output  1  register-file write
- reg_dst_o  output  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg_o  output  2  00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a_o  output  1  0 = PC, 1 = A
- alu_src_b_o  output  2  00 = B, 01 = 4, 10 = sign/zero-extended imm, 11 = sign-extended imm<<2
- zero_ext_o  output  1  1 = zero-extend immediate (ANDI/ORI)
- pc_source_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (JR)
- alu_op_o  output  3  to ALU control alu_op_i
- illegal_o  output  1  one-cycle pulse on unsupported opcode
- state_o  output  4  current state, for debug

## Operation
Opcodes: R = 000000, J = 000010, JAL = 000011, BEQ = 000100, BNE = 000101, ADDI = 001000, ANDI = 001100, ORI = 001101, LUI = 001111, LW = 100011, SW = 101011.

ALU-op codes: 111 = R-type, 100 = add, 101 = ori, 001 = andi, 110 = lui, 011 = lw/sw, 010 = branch subtract.

States and Moore outputs (unlisted outputs are 0):
- FETCH: mem_read, ir_write, pc_write; src_a = 0, src_b = 01, alu_op = 100, pc_source = 00. Next state: DECODE.
- DECODE: src_a = 0, src_b = 11, alu_op = 100 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEM_ADDR
  - R → R_EXEC
  - ADDI/ANDI/ORI/LUI → I_EXEC
  - BEQ/BNE → BRANCH
  - J → JUMP
  - JAL → JAL_ST
  - any other opcode → FETCH, with illegal_o asserted for this cycle
- MEM_ADDR: src_a = 1, src_b = 10, alu_op = 011. Next state: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read, i_or_d = 1. Next state: MEM_WB.
- MEM_WB: reg_write, reg_dst = 00, mem_to_reg = 01. Next state: FETCH.
- MEM_WRITE: mem_write, i_or_d = 1. Next state: FETCH.
- R_EXEC: src_a = 1, src_b = 00, alu_op = 111.
  - If jmp_ctl_i == 10: pc_write, pc_source = 11; next state FETCH.
  - Otherwise: next state R_WB.
- R_WB: reg_write, reg_dst = 01, mem_to_reg = 00. Next state: FETCH.
- I_EXEC: src_a = 1, src_b = 10, alu_op per opcode, zero_ext = 1 for ANDI/ORI. Next state: I_WB.
- I_WB: reg_write, reg_dst = 00, mem_to_reg = 00; alu_op and zero_ext held. Next state: FETCH.
- BRANCH: src_a = 1, src_b = 00, alu_op = 010, pc_write_cond, pc_source = 01, branch_ne = (opcode == BNE). Next state: FETCH.
- JUMP: pc_write, pc_source = 10. Next state: FETCH.
- JAL_ST: pc_write, pc_source = 10, reg_write, reg_dst = 10, mem_to_reg = 10. Next state: FETCH.

opcode_i is read only in DECODE, MEM_ADDR, I_EXEC, I_WB and BRANCH. The IR holds it stable after FETCH.

## Timing
- Reset: state ← FETCH on the edge where reset = 1. While reset is high, every output is forced to 0, including state_o = 0 (FETCH encoding = 4'd0).
- Reset mid-instruction aborts that instruction; no write enable is asserted in the reset cycle.
- First FETCH outputs appear in the cycle after reset deasserts.
- Outputs are combinational from the registered state (Moore), except two Mealy terms: R_EXEC's dependence on jmp_ctl_i and DECODE's illegal_o.
- jmp_ctl_i must be valid within R_EXEC; ALU control's path is combinational from alu_op_o and funct.
- Cycles per instruction: LW 5; SW, R, I-type 4; BEQ/BNE, J, JAL, JR 3; illegal 2.
- State encoding is 4 bits, 13 states. Unused encodings → FETCH on the next edge.

## Structure
- Package mips_ctl_pkg holds: opcode localparams, alu_op codes, state enum, and the reg_dst, mem_to_reg, alu_src_b and pc_source encodings. ALU control shares the alu_op codes from this package.
- One sub-module, opcode_class_decoder: combinational, opcode → one-hot class (mem, r, imm, branch, jump, jal, illegal) plus the I-type alu_op. It is used by both the next-state and output logic.
- State register and output decode live in multicycle_control_unit.

## Test plan
- Reset held 3 cycles mid-LW (state MEM_READ) → all outputs 0 while reset is high; state_o = 0; first post-reset cycle has ir_write = 1, mem_read = 1.
- LW (100011) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; alu_op = 011 in MEM_ADDR; reg_write with mem_to_reg = 01 in cycle 5 only.
- R-type ADD with jmp_ctl_i = 00, then JR with jmp_ctl_i = 10:
  - ADD → 4 cycles, reg_dst = 01.
  - JR → 3 cycles, pc_source = 11, pc_write = 1, reg_write never asserted.
- BNE (000101) → BRANCH state has pc_write_cond = 1, branch_ne = 1, alu_op = 010, pc_source = 01; BEQ has branch_ne = 0.
- ORI, then JAL → ORI: alu_op = 101 and zero_ext = 1 across I_EXEC/I_WB. JAL: reg_dst = 10, mem_to_reg = 10, pc_source = 10, 3 cycles.
- Opcode 111111 → illegal_o pulses one cycle in DECODE; next state FETCH; no write enables asserted.
